// File: rtl/modport_slave.sv
// AXI4 slave over a byte-strobed register memory; independent single-outstanding
// write (AW/W/B) and read (AR/R) state machines.
module modport_slave #(
    parameter int ID_W      = 6,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ID_W-1:0]     S0_AWID,
    input  logic [ADDR_W-1:0]   S0_AWADDR,
    input  logic [3:0]          S0_AWLEN,
    input  logic [2:0]          S0_AWSIZE,
    input  logic [1:0]          S0_AWBURST,
    input  logic                S0_AWLOCK,
    input  logic [3:0]          S0_AWCACHE,
    input  logic [2:0]          S0_AWPROT,
    input  logic [3:0]          S0_AWQOS,
    input  logic [3:0]          S0_AWREGION,
    input  logic                S0_AWUSER,
    input  logic                S0_AWVALID,
    output logic                S0_AWREADY,
    input  logic [DATA_W-1:0]   S0_WDATA,
    input  logic [DATA_W/8-1:0] S0_WSTRB,
    input  logic                S0_WLAST,
    input  logic                S0_WUSER,
    input  logic                S0_WVALID,
    output logic                S0_WREADY,
    output logic [ID_W-1:0]     S0_BID,
    output logic [1:0]          S0_BRESP,
    output logic                S0_BUSER,
    output logic                S0_BVALID,
    input  logic                S0_BREADY,
    input  logic [ID_W-1:0]     S0_ARID,
    input  logic [ADDR_W-1:0]   S0_ARADDR,
    input  logic [3:0]          S0_ARLEN,
    input  logic [2:0]          S0_ARSIZE,
    input  logic [1:0]          S0_ARBURST,
    input  logic                S0_ARLOCK,
    input  logic [3:0]          S0_ARCACHE,
    input  logic [2:0]          S0_ARPROT,
    input  logic [3:0]          S0_ARQOS,
    input  logic [3:0]          S0_ARREGION,
    input  logic                S0_ARUSER,
    input  logic                S0_ARVALID,
    output logic                S0_ARREADY,
    output logic [ID_W-1:0]     S0_RID,
    output logic [DATA_W-1:0]   S0_RDATA,
    output logic [1:0]          S0_RRESP,
    output logic                S0_RLAST,
    output logic                S0_RUSER,
    output logic                S0_RVALID,
    input  logic                S0_RREADY
);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] a,
        input logic [3:0]        len,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] step, mask, sum;
        step = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        sum  = a + step;
        case (burst)
            2'b00:   next_addr = a;
            2'b10:   next_addr = (a & ~mask) | (sum & mask);
            default: next_addr = sum;
        endcase
    endfunction

    logic [DATA_W-1:0] mem [MEM_WORDS];

    wstate_t           wstate;
    logic              aw_ready, w_ready, b_valid, w_over;
    logic [ID_W-1:0]   aw_id, b_id;
    logic [1:0]        b_resp, w_burst;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_len, w_cnt;
    logic [2:0]        w_size;
    logic              w_fire;

    rstate_t           rstate;
    logic              ar_ready, r_valid, r_last;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_len, r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;

    assign w_fire = S0_WVALID && w_ready;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int unsigned i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else if (w_fire) begin
            for (int unsigned b = 0; b < STRB_W; b++)
                if (S0_WSTRB[b]) mem[w_addr[IDX_W+1:2]][b*8 +: 8] <= S0_WDATA[b*8 +: 8];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wstate   <= W_IDLE;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_id     <= '0;
            b_resp   <= '0;
            aw_id    <= '0;
            w_addr   <= '0;
            w_len    <= '0;
            w_size   <= '0;
            w_burst  <= '0;
            w_cnt    <= '0;
            w_over   <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (S0_AWVALID && aw_ready) begin
                        aw_id    <= S0_AWID;
                        w_addr   <= S0_AWADDR;
                        w_len    <= S0_AWLEN;
                        w_size   <= S0_AWSIZE;
                        w_burst  <= S0_AWBURST;
                        w_cnt    <= '0;
                        w_over   <= 1'b0;
                        aw_ready <= 1'b0;
                        w_ready  <= 1'b1;
                        wstate   <= W_DATA;
                    end else begin
                        aw_ready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                        w_cnt  <= w_cnt + 4'd1;
                        // Once the LEN beat passes without WLAST the burst is
                        // already in error, whatever the counter later wraps to.
                        if (!S0_WLAST && (w_cnt == w_len)) w_over <= 1'b1;
                        if (S0_WLAST) begin
                            w_ready <= 1'b0;
                            b_valid <= 1'b1;
                            b_id    <= aw_id;
                            b_resp  <= ((w_cnt == w_len) && !w_over) ? 2'b00 : 2'b10;
                            wstate  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S0_BREADY) begin
                        b_valid  <= 1'b0;
                        aw_ready <= 1'b1;
                        wstate   <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rstate   <= R_IDLE;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_id     <= '0;
            r_data   <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_cnt    <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (S0_ARVALID && ar_ready) begin
                        ar_ready <= 1'b0;
                        r_valid  <= 1'b1;
                        r_id     <= S0_ARID;
                        r_data   <= mem[S0_ARADDR[IDX_W+1:2]];
                        r_last   <= (S0_ARLEN == 4'd0);
                        r_addr   <= next_addr(S0_ARADDR, S0_ARLEN, S0_ARSIZE, S0_ARBURST);
                        r_len    <= S0_ARLEN;
                        r_size   <= S0_ARSIZE;
                        r_burst  <= S0_ARBURST;
                        r_cnt    <= '0;
                        rstate   <= R_DATA;
                    end else begin
                        ar_ready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S0_RREADY) begin
                        if (r_last) begin
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            ar_ready <= 1'b1;
                            rstate   <= R_IDLE;
                        end else begin
                            // r_addr already points at the beat being loaded now
                            r_data <= mem[r_addr[IDX_W+1:2]];
                            r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
                            r_cnt  <= r_cnt + 4'd1;
                            r_last <= ((r_cnt + 4'd1) == r_len);
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign S0_AWREADY = aw_ready;
    assign S0_WREADY  = w_ready;
    assign S0_BVALID  = b_valid;
    assign S0_BID     = b_id;
    assign S0_BRESP   = b_resp;
    assign S0_BUSER   = 1'b0;
    assign S0_ARREADY = ar_ready;
    assign S0_RVALID  = r_valid;
    assign S0_RID     = r_id;
    assign S0_RDATA   = r_data;
    assign S0_RRESP   = 2'b00;
    assign S0_RLAST   = r_last;
    assign S0_RUSER   = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{S0_AWLOCK, S0_AWCACHE, S0_AWPROT, S0_AWQOS, S0_AWREGION, S0_AWUSER,
                         S0_WUSER, S0_ARLOCK, S0_ARCACHE, S0_ARPROT, S0_ARQOS, S0_ARREGION,
                         S0_ARUSER};
endmodule

// File: tb/tb_modport_slave.sv
// Directed bench for modport_slave: expected B responses and R beats are queued
// when stimulus is issued and checked as the slave returns them.
module tb_modport_slave;
    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [5:0]  S0_AWID;
    logic [31:0] S0_AWADDR;
    logic [3:0]  S0_AWLEN;
    logic [2:0]  S0_AWSIZE;
    logic [1:0]  S0_AWBURST;
    logic        S0_AWVALID;
    logic        S0_AWREADY;
    logic [31:0] S0_WDATA;
    logic [3:0]  S0_WSTRB;
    logic        S0_WLAST;
    logic        S0_WVALID;
    logic        S0_WREADY;
    logic [5:0]  S0_BID;
    logic [1:0]  S0_BRESP;
    logic        S0_BUSER;
    logic        S0_BVALID;
    logic        S0_BREADY;
    logic [5:0]  S0_ARID;
    logic [31:0] S0_ARADDR;
    logic [3:0]  S0_ARLEN;
    logic [2:0]  S0_ARSIZE;
    logic [1:0]  S0_ARBURST;
    logic        S0_ARVALID;
    logic        S0_ARREADY;
    logic [5:0]  S0_RID;
    logic [31:0] S0_RDATA;
    logic [1:0]  S0_RRESP;
    logic        S0_RLAST;
    logic        S0_RUSER;
    logic        S0_RVALID;
    logic        S0_RREADY;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] rq[$];
    logic [1:0]  bq[$];
    logic [31:0] wd[16];
    logic [3:0]  ws[16];

    always #5 ACLK = ~ACLK;

    modport_slave #(.ID_W(6), .ADDR_W(32), .DATA_W(32), .MEM_WORDS(256)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .S0_AWID(S0_AWID), .S0_AWADDR(S0_AWADDR), .S0_AWLEN(S0_AWLEN),
        .S0_AWSIZE(S0_AWSIZE), .S0_AWBURST(S0_AWBURST), .S0_AWLOCK(1'b0),
        .S0_AWCACHE(4'h0), .S0_AWPROT(3'h0), .S0_AWQOS(4'h0), .S0_AWREGION(4'h0),
        .S0_AWUSER(1'b0), .S0_AWVALID(S0_AWVALID), .S0_AWREADY(S0_AWREADY),
        .S0_WDATA(S0_WDATA), .S0_WSTRB(S0_WSTRB), .S0_WLAST(S0_WLAST), .S0_WUSER(1'b0),
        .S0_WVALID(S0_WVALID), .S0_WREADY(S0_WREADY),
        .S0_BID(S0_BID), .S0_BRESP(S0_BRESP), .S0_BUSER(S0_BUSER),
        .S0_BVALID(S0_BVALID), .S0_BREADY(S0_BREADY),
        .S0_ARID(S0_ARID), .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN),
        .S0_ARSIZE(S0_ARSIZE), .S0_ARBURST(S0_ARBURST), .S0_ARLOCK(1'b0),
        .S0_ARCACHE(4'h0), .S0_ARPROT(3'h0), .S0_ARQOS(4'h0), .S0_ARREGION(4'h0),
        .S0_ARUSER(1'b0), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
        .S0_RID(S0_RID), .S0_RDATA(S0_RDATA), .S0_RRESP(S0_RRESP), .S0_RLAST(S0_RLAST),
        .S0_RUSER(S0_RUSER), .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY)
    );

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       sig = S0_AWREADY;
            1:       sig = S0_WREADY;
            2:       sig = S0_BVALID;
            3:       sig = S0_ARREADY;
            default: sig = S0_RVALID;
        endcase
    endfunction

    task automatic wait_hi(input int sel, input string tag);
        int n = 0;
        while (sig(sel) !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        assert (n < 100) else begin
            miscompares++;
            $error("FAIL %s timeout observed=%0d cycles expected=<100", tag, n);
        end
    endtask

    task automatic wr(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input int nb,
                      input logic [1:0] resp);
        logic [1:0] e;
        bq.push_back(resp);
        S0_AWID = id; S0_AWADDR = addr; S0_AWLEN = len; S0_AWSIZE = size;
        S0_AWBURST = burst; S0_AWVALID = 1'b1;
        wait_hi(0, "awready");
        tick();
        S0_AWVALID = 1'b0;
        for (int i = 0; i < nb; i++) begin
            S0_WDATA = wd[i]; S0_WSTRB = ws[i]; S0_WLAST = (i == nb - 1); S0_WVALID = 1'b1;
            wait_hi(1, "wready");
            tick();
            S0_WVALID = 1'b0; S0_WLAST = 1'b0;
        end
        S0_BREADY = 1'b1;
        wait_hi(2, "bvalid");
        e = bq.pop_front();
        chk("bresp", 64'(S0_BRESP), 64'(e));
        chk("bid", 64'(S0_BID), 64'(id));
        tick();
        S0_BREADY = 1'b0;
        chk("b_done", 64'(S0_BVALID), 64'd0);
        chk("awready_after_b", 64'(S0_AWREADY), 64'd1);
    endtask

    task automatic rd(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input int stall_beat);
        logic [31:0] e;
        S0_ARID = id; S0_ARADDR = addr; S0_ARLEN = len; S0_ARSIZE = size;
        S0_ARBURST = burst; S0_ARVALID = 1'b1;
        wait_hi(3, "arready");
        tick();
        S0_ARVALID = 1'b0;
        S0_RREADY = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            wait_hi(4, "rvalid");
            e = rq.pop_front();
            if (i == stall_beat) begin
                S0_RREADY = 1'b0;
                repeat (3) begin
                    tick();
                    chk("r_hold_valid", 64'(S0_RVALID), 64'd1);
                    chk("r_hold_data", 64'(S0_RDATA), 64'(e));
                    chk("r_hold_last", 64'(S0_RLAST), 64'(i == int'(len)));
                end
                S0_RREADY = 1'b1;
            end
            chk("rdata", 64'(S0_RDATA), 64'(e));
            chk("rid", 64'(S0_RID), 64'(id));
            chk("rlast", 64'(S0_RLAST), 64'(i == int'(len)));
            chk("rresp", 64'(S0_RRESP), 64'd0);
            tick();
        end
        S0_RREADY = 1'b0;
        chk("r_done", 64'(S0_RVALID), 64'd0);
    endtask

    initial begin
        ARESETn = 1'b0;
        S0_AWID = '0; S0_AWADDR = '0; S0_AWLEN = '0; S0_AWSIZE = '0; S0_AWBURST = '0;
        S0_AWVALID = 1'b0; S0_WDATA = '0; S0_WSTRB = '0; S0_WLAST = 1'b0; S0_WVALID = 1'b0;
        S0_BREADY = 1'b0; S0_ARID = '0; S0_ARADDR = '0; S0_ARLEN = '0; S0_ARSIZE = '0;
        S0_ARBURST = '0; S0_ARVALID = 1'b0; S0_RREADY = 1'b0;
        for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 4'hF; end

        repeat (2) tick();
        chk("rst_awready", 64'(S0_AWREADY), 64'd0);
        chk("rst_arready", 64'(S0_ARREADY), 64'd0);
        chk("rst_bvalid", 64'(S0_BVALID), 64'd0);
        chk("rst_rvalid", 64'(S0_RVALID), 64'd0);
        ARESETn = 1'b1;
        tick();
        chk("rel_awready", 64'(S0_AWREADY), 64'd1);
        chk("rel_arready", 64'(S0_ARREADY), 64'd1);

        // single beat write then read
        wd[0] = 32'hDEADBEEF;
        wr(6'd5, 32'h10, 4'd0, 3'd2, 2'b01, 1, 2'b00);
        rq.push_back(32'hDEADBEEF);
        rd(6'd9, 32'h10, 4'd0, 3'd2, 2'b01, -1);

        // INCR burst of four
        for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
        wr(6'd12, 32'h20, 4'd3, 3'd2, 2'b01, 4, 2'b00);
        for (int i = 0; i < 4; i++) rq.push_back(32'(i + 1));
        rd(6'd33, 32'h20, 4'd3, 3'd2, 2'b01, -1);

        // WRAP burst from 0x38 lands on 0x38, 0x3C, 0x30, 0x34
        wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
        wr(6'd7, 32'h38, 4'd3, 3'd2, 2'b10, 4, 2'b00);
        rq.push_back(32'hA2); rq.push_back(32'hA3); rq.push_back(32'hA0); rq.push_back(32'hA1);
        rd(6'd1, 32'h30, 4'd3, 3'd2, 2'b01, -1);
        rq.push_back(32'hA0); rq.push_back(32'hA1); rq.push_back(32'hA2); rq.push_back(32'hA3);
        rd(6'd2, 32'h38, 4'd3, 3'd2, 2'b10, -1);

        // FIXED burst keeps hitting one word
        wd[0] = 32'h11; wd[1] = 32'h22;
        wr(6'd4, 32'h60, 4'd1, 3'd2, 2'b00, 2, 2'b00);
        rq.push_back(32'h22); rq.push_back(32'h0);
        rd(6'd4, 32'h60, 4'd1, 3'd2, 2'b01, -1);

        // partial strobes over zero, read with RREADY stalled
        wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
        wr(6'd3, 32'h40, 4'd0, 3'd2, 2'b01, 1, 2'b00);
        ws[0] = 4'hF;
        rq.push_back(32'h00BB00DD);
        rd(6'd6, 32'h40, 4'd0, 3'd2, 2'b01, 0);
        rq.push_back(32'h3); rq.push_back(32'h4);
        rd(6'd6, 32'h28, 4'd1, 3'd2, 2'b01, 0);

        // early WLAST on beat 1, and a WLAST arriving after the LEN beat
        wr(6'd10, 32'h50, 4'd3, 3'd2, 2'b01, 2, 2'b10);
        wr(6'd11, 32'h70, 4'd1, 3'd2, 2'b01, 3, 2'b10);

        // reset while read beat 2 is presented
        S0_ARID = 6'd3; S0_ARADDR = 32'h20; S0_ARLEN = 4'd3; S0_ARSIZE = 3'd2;
        S0_ARBURST = 2'b01; S0_ARVALID = 1'b1;
        wait_hi(3, "arready_rst");
        tick();
        S0_ARVALID = 1'b0;
        S0_RREADY = 1'b1;
        wait_hi(4, "rvalid_rst");
        chk("rst_beat0", 64'(S0_RDATA), 64'd1);
        tick();
        chk("rst_beat1", 64'(S0_RDATA), 64'd2);
        tick();
        chk("rst_beat2", 64'(S0_RDATA), 64'd3);
        ARESETn = 1'b0;
        #1;
        chk("midrst_rvalid", 64'(S0_RVALID), 64'd0);
        chk("midrst_arready", 64'(S0_ARREADY), 64'd0);
        chk("midrst_rlast", 64'(S0_RLAST), 64'd0);
        S0_RREADY = 1'b0;
        tick();
        ARESETn = 1'b1;
        tick();
        chk("postrst_arready", 64'(S0_ARREADY), 64'd1);
        chk("postrst_awready", 64'(S0_AWREADY), 64'd1);
        chk("postrst_rvalid", 64'(S0_RVALID), 64'd0);

        // memory was cleared by the reset
        rq.push_back(32'h0);
        rd(6'd8, 32'h20, 4'd0, 3'd2, 2'b01, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
